handshake_rr_scheduler: RTL and testbench

- Shares one downstream filter-core input between N_CH handshake receiver channels.
- Each channel delivers a word plus a one-cycle "new data ready" pulse, already synchronised to clk_fpga.
- The block buffers one word per channel and grants the channels round-robin.
- The winning word and its channel ID are presented on a valid/ready interface.

---
 rtl/handshake_rr_scheduler.sv | 158 +++++++++++++++
 tb/tb_handshake_rr_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rr_scheduler.sv
// handshake_rr_scheduler: buffers one word per receiver channel and
// grants pending channels round-robin onto a single valid/ready output.
//
// Ports:
//   clk_fpga        system clock
//   reset           asynchronous, active-high reset
//   i_enable        allows new grants (a transfer in flight always completes)
//   i_ch_dado       packed channel words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_ch_pronto     per-channel one-cycle "new word" pulse
//   o_dado          granted word
//   o_canal         granted channel index
//   o_valid         o_dado/o_canal valid
//   i_ready         downstream accepts on o_valid && i_ready at an edge
//   o_overrun       sticky per-channel overrun flags
//   i_clr_overrun   clears all o_overrun bits
//   o_busy          transfer in flight or any slot pending
module handshake_rr_scheduler #(
  parameter  int N_CH       = 4,
  parameter  int DATA_WIDTH = 4,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic                       clk_fpga,
  input  logic                       reset,
  input  logic                       i_enable,
  input  logic [N_CH*DATA_WIDTH-1:0] i_ch_dado,
  input  logic [N_CH-1:0]            i_ch_pronto,
  output logic [DATA_WIDTH-1:0]      o_dado,
  output logic [CH_W-1:0]            o_canal,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [N_CH-1:0]            o_overrun,
  input  logic                       i_clr_overrun,
  output logic                       o_busy
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [N_CH-1:0]       pend_q;
  logic [DATA_WIDTH-1:0] slot_q [N_CH];
  logic [CH_W-1:0]       rr_q;
  logic [CH_W-1:0]       rr_d;
  logic                  valid_d;
  logic [DATA_WIDTH-1:0] dado_d;
  logic [CH_W-1:0]       canal_d;

  logic                  drain;
  logic [N_CH-1:0]       drain_hit;
  logic [N_CH-1:0]       ovr_set;
  logic                  sel_found;
  logic [CH_W-1:0]       sel_idx;
  logic [CH_W-1:0]       cand;

  assign drain     = o_valid && i_ready;
  assign drain_hit = drain ? (N_CH'(1) << o_canal) : '0;

  // A slot being drained this edge frees up, so a pulse on it is
  // a legal capture rather than an overrun.
  assign ovr_set   = i_ch_pronto & pend_q & ~drain_hit;

  assign o_busy    = (state_q == SEND) || (|pend_q);

  // Rotating search starting at rr_q; first pending channel wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = CH_W'((int'(rr_q) + i) % N_CH);
      if (!sel_found && pend_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = o_valid;
    dado_d  = o_dado;
    canal_d = o_canal;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (i_enable && sel_found) begin
          dado_d  = slot_q[sel_idx];
          canal_d = sel_idx;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (o_canal == CH_W'(N_CH - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = o_canal + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      o_valid <= 1'b0;
      o_dado  <= '0;
      o_canal <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      o_valid <= valid_d;
      o_dado  <= dado_d;
      o_canal <= canal_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      for (int k = 0; k < N_CH; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_ch_pronto[k] && (!pend_q[k] || drain_hit[k])) begin
          slot_q[k] <= i_ch_dado[k*DATA_WIDTH +: DATA_WIDTH];
          pend_q[k] <= 1'b1;
        end else if (drain_hit[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
    end
  end

  // A fresh overrun on the clearing edge keeps its bit set.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      o_overrun <= '0;
    end else begin
      o_overrun <= (i_clr_overrun ? '0 : o_overrun) | ovr_set;
    end
  end

endmodule

// File: tb/tb_handshake_rr_scheduler.sv
// Scoreboard bench for handshake_rr_scheduler (N_CH=4, DATA_WIDTH=4).
// Stimulus pushes expected {canal,dado}; a monitor pops on each accept.
module tb_handshake_rr_scheduler;

  localparam int N_CH = 4;
  localparam int DW   = 4;
  localparam int CW   = 2;

  logic             clk_fpga;
  logic             reset;
  logic             i_enable;
  logic [N_CH*DW-1:0] i_ch_dado;
  logic [N_CH-1:0]  i_ch_pronto;
  logic [DW-1:0]    o_dado;
  logic [CW-1:0]    o_canal;
  logic             o_valid;
  logic             i_ready;
  logic [N_CH-1:0]  o_overrun;
  logic             i_clr_overrun;
  logic             o_busy;

  int total = 0;
  int bad   = 0;

  logic [CW+DW-1:0] exp_q [$];

  handshake_rr_scheduler #(
    .N_CH      (N_CH),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_fpga     (clk_fpga),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_ch_dado    (i_ch_dado),
    .i_ch_pronto  (i_ch_pronto),
    .o_dado       (o_dado),
    .o_canal      (o_canal),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_overrun    (o_overrun),
    .i_clr_overrun(i_clr_overrun),
    .o_busy       (o_busy)
  );

  initial clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic push(input int ch, input int d);
    exp_q.push_back({CW'(ch), DW'(d)});
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((o_busy || o_valid) && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 32'(o_busy || o_valid), 0);
  endtask

  // Accept happens at the next rising edge when both are high here.
  always @(negedge clk_fpga) begin
    if (!reset && o_valid && i_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got ch=%0d d=%0h expected none",
                 o_canal, o_dado);
      end else begin
        logic [CW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({o_canal, o_dado} !== e) begin
          bad++;
          $display("FAIL sb_grant: got ch=%0d d=%0h expected ch=%0d d=%0h",
                   o_canal, o_dado, e[CW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    reset         = 1'b1;
    i_enable      = 1'b0;
    i_ch_dado     = '0;
    i_ch_pronto   = '0;
    i_ready       = 1'b0;
    i_clr_overrun = 1'b0;
    #2;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_dado", 32'(o_dado), 0);
    chk("rst_canal", 32'(o_canal), 0);
    chk("rst_ovr", 32'(o_overrun), 0);
    chk("rst_busy", 32'(o_busy), 0);
    tick();
    tick();
    reset    = 1'b0;
    i_enable = 1'b1;
    i_ready  = 1'b1;

    // single word on ch2
    i_ch_pronto = 4'b0100;
    i_ch_dado   = 16'h0A00;
    push(2, 'hA);
    tick();
    i_ch_pronto = '0;
    chk("t1_lat_valid", 32'(o_valid), 0);
    chk("t1_busy_pend", 32'(o_busy), 1);
    tick();
    chk("t1_valid", 32'(o_valid), 1);
    chk("t1_canal", 32'(o_canal), 2);
    chk("t1_dado", 32'(o_dado), 'hA);
    tick();
    chk("t1_done_valid", 32'(o_valid), 0);
    chk("t1_done_busy", 32'(o_busy), 0);

    // round robin from rr_ptr=0 with one-cycle gaps
    reset = 1'b1;
    #1;
    reset = 1'b0;
    i_ch_pronto = 4'b1111;
    i_ch_dado   = 16'h4321;
    push(0, 1);
    push(1, 2);
    push(2, 3);
    push(3, 4);
    tick();
    i_ch_pronto = '0;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat = {pat[6:0], o_valid};
    end
    chk("t2_gap_pattern", 32'(pat), 'hAA);
    chk("t2_busy", 32'(o_busy), 0);

    // bring rr_ptr to 3 via a ch2 grant
    i_ch_pronto = 4'b0100;
    i_ch_dado   = 16'h0700;
    push(2, 7);
    tick();
    i_ch_pronto = '0;
    wait_idle("t3_idle_a");
    // rr_ptr=3: ch3 before ch1, wrap
    i_enable    = 1'b0;
    i_ch_pronto = 4'b1010;
    i_ch_dado   = 16'hB090;
    push(3, 'hB);
    push(1, 9);
    tick();
    i_ch_pronto = '0;
    i_enable    = 1'b1;
    wait_idle("t3_idle_b");
    // rr_ptr=2: ch2 before ch1
    i_ch_pronto = 4'b0110;
    i_ch_dado   = 16'h0DC0;
    push(2, 'hD);
    push(1, 'hC);
    tick();
    i_ch_pronto = '0;
    wait_idle("t3_idle_c");

    // backpressure, enable dropped mid-transfer
    i_ready     = 1'b0;
    i_ch_pronto = 4'b0001;
    i_ch_dado   = 16'h0006;
    push(0, 6);
    tick();
    i_ch_pronto = '0;
    tick();
    i_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(o_valid), 1);
      chk("t4_hold_dado", 32'(o_dado), 6);
      chk("t4_hold_canal", 32'(o_canal), 0);
      tick();
    end
    i_ready = 1'b1;
    tick();
    chk("t4_done_valid", 32'(o_valid), 0);
    i_enable = 1'b1;
    wait_idle("t4_idle");

    // overrun on ch0
    i_enable    = 1'b0;
    i_ch_pronto = 4'b0001;
    i_ch_dado   = 16'h0003;
    tick();
    i_ch_dado = 16'h0005;
    tick();
    i_ch_pronto = '0;
    chk("t5_ovr_set", 32'(o_overrun), 1);
    i_ch_pronto   = 4'b0001;
    i_ch_dado     = 16'h0008;
    i_clr_overrun = 1'b1;
    tick();
    i_ch_pronto   = '0;
    i_clr_overrun = 1'b0;
    chk("t5_ovr_wins", 32'(o_overrun), 1);
    i_clr_overrun = 1'b1;
    tick();
    i_clr_overrun = 1'b0;
    chk("t5_ovr_clr", 32'(o_overrun), 0);
    push(0, 3);
    i_enable = 1'b1;
    wait_idle("t5_idle");

    // drain-edge capture on ch1
    i_ready     = 1'b0;
    i_ch_pronto = 4'b0010;
    i_ch_dado   = 16'h00E0;
    push(1, 'hE);
    tick();
    i_ch_pronto = '0;
    tick();
    chk("t6_valid_e", 32'(o_valid), 1);
    chk("t6_canal_e", 32'(o_canal), 1);
    i_ready     = 1'b1;
    i_ch_pronto = 4'b0010;
    i_ch_dado   = 16'h00F0;
    push(1, 'hF);
    tick();
    i_ch_pronto = '0;
    chk("t6_gap_valid", 32'(o_valid), 0);
    chk("t6_no_ovr", 32'(o_overrun), 0);
    chk("t6_busy", 32'(o_busy), 1);
    tick();
    chk("t6_regrant_valid", 32'(o_valid), 1);
    chk("t6_regrant_canal", 32'(o_canal), 1);
    chk("t6_regrant_dado", 32'(o_dado), 'hF);
    tick();
    // reset while a word is offered
    i_ready     = 1'b0;
    i_ch_pronto = 4'b1000;
    i_ch_dado   = 16'h2000;
    tick();
    i_ch_pronto = '0;
    tick();
    chk("t7_pre_valid", 32'(o_valid), 1);
    chk("t7_pre_canal", 32'(o_canal), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_rst_valid", 32'(o_valid), 0);
    chk("t7_rst_dado", 32'(o_dado), 0);
    chk("t7_rst_canal", 32'(o_canal), 0);
    chk("t7_rst_busy", 32'(o_busy), 0);
    chk("t7_rst_ovr", 32'(o_overrun), 0);
    tick();
    reset   = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    chk("t7_post_valid", 32'(o_valid), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
